// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-ported register file: FSM state encoding
// and default geometry constants.
package regfile_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_NRD   = 2;
    localparam int RF_NWR   = 2;

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter for one queried address: reports whether any enabled
// write port targets q_addr and, if several do, the highest-index port's data.
import regfile_pkg::*;

module regfile_wr_arb #(
    parameter int XLEN = RF_XLEN,
    parameter int AW   = $clog2(RF_NREGS),
    parameter int NWR  = RF_NWR
) (
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic [AW-1:0]            q_addr,
    output logic                     hit,
    output logic [XLEN-1:0]          data
);

    // Ascending scan so the last (highest-index) matching port overrides.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j] == q_addr)) begin
                hit  = 1'b1;
                data = wr_data[j];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with power-up clear sweep, write bypass and an
// optional issue scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
import regfile_pkg::*;

module regfile_mp #(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD,
    parameter int NWR   = RF_NWR,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic [NRD-1:0]           rd_en,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [NREGS-1:0]         busy_vec
);

    rf_state_e       state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic            run;
    logic [NWR-1:0]  wr_en_run;

    logic [NREGS-1:0] st_hit;
    logic [XLEN-1:0]  st_data [NREGS];
    logic [NRD-1:0]   byp_hit;
    logic [XLEN-1:0]  byp_data [NRD];
    logic [XLEN-1:0]  regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RF_INIT: begin
                cnt_nxt = cnt + AW'(1);
                if (cnt == AW'(NREGS - 1)) begin
                    state_nxt = RF_RUN;
                    cnt_nxt   = '0;
                end
            end
            RF_RUN:  ;
            default: state_nxt = RF_INIT;
        endcase
    end

    assign run       = (state == RF_RUN);
    assign init_done = run;
    // Writes have no effect anywhere (storage, bypass, scoreboard) until the sweep is done.
    assign wr_en_run = wr_en & {NWR{run}};

    for (genvar r = 0; r < NREGS; r++) begin : g_st
        regfile_wr_arb #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
            .wr_en   (wr_en_run),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .q_addr  (AW'(r)),
            .hit     (st_hit[r]),
            .data    (st_data[r])
        );
    end

    for (genvar i = 0; i < NRD; i++) begin : g_byp
        regfile_wr_arb #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
            .wr_en   (wr_en_run),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .q_addr  (rd_addr[i]),
            .hit     (byp_hit[i]),
            .data    (byp_data[i])
        );
    end

    // Storage is never touched by rst; only the INIT sweep zeroes it.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (!run) begin
                if (cnt == AW'(r)) regs[r] <= '0;
            end else if (st_hit[r] && (r != 0)) begin
                regs[r] <= st_data[r];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (run && rd_en[i] && (rd_addr[i] != '0))
                rd_data[i] = byp_hit[i] ? byp_data[i] : regs[rd_addr[i]];
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREGS-1:0] busy;

    // Issue is checked before write-clear so a same-cycle collision stays busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (run) begin
            for (int r = 0; r < NREGS; r++) begin
                if (r == 0)
                    busy[r] <= 1'b0;
                else if (iss_en && (iss_addr == AW'(r)))
                    busy[r] <= 1'b1;
                else if (st_hit[r])
                    busy[r] <= 1'b0;
            end
        end
    end

    assign busy_vec = busy;

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++)
            rd_busy[i] = run & rd_en[i] & busy[rd_addr[i]] & ~byp_hit[i];
    end
`else
    logic unused_iss;

    assign busy_vec   = '0;
    assign rd_busy    = '0;
    assign unused_iss = ^{iss_en, iss_addr};
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against an array-based model;
// scoreboard expectations follow REGFILE_SCOREBOARD_EN.
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     init_done;
    logic [NRD-1:0]           rd_en;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic [NREGS-1:0]         busy_vec;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .busy_vec  (busy_vec)
    );

    // Reference model: register contents, pending flags, sweep progress.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    bit              m_run  = 1'b0;
    int              m_left = NREGS;

    int              tests = 0;
    int              fails = 0;
    bit              chk_on = 1'b0;
    int              lit_kind = 0;
    int              lit_idx  = 0;
    logic [XLEN-1:0] lit_exp  = '0;
    string           lit_name = "";

    always @(posedge clk) begin
        if (rst) begin
            m_run  = 1'b0;
            m_left = NREGS;
            for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
        end else if (!m_run) begin
            m_regs[NREGS - m_left] = '0;
            m_left = m_left - 1;
            if (m_left == 0) m_run = 1'b1;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    if (wr_addr[j] != 0) m_regs[wr_addr[j]] = wr_data[j];
                    m_busy[wr_addr[j]] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
            m_busy[0] = 1'b0;
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(int i);
        if (!m_run || !rd_en[i] || rd_addr[i] == 0) return '0;
        for (int j = NWR - 1; j >= 0; j--)
            if (wr_en[j] && wr_addr[j] == rd_addr[i]) return wr_data[j];
        return m_regs[rd_addr[i]];
    endfunction

    function automatic logic exp_rbusy(int i);
`ifdef REGFILE_SCOREBOARD_EN
        if (!m_run || !rd_en[i]) return 1'b0;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j] == rd_addr[i]) return 1'b0;
        return m_busy[rd_addr[i]];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [NREGS-1:0] exp_bvec();
        logic [NREGS-1:0] v;
        v = '0;
`ifdef REGFILE_SCOREBOARD_EN
        for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
`endif
        return v;
    endfunction

    always @(negedge clk) begin : compare
        logic [XLEN-1:0] act;
        if (chk_on) begin
            tests++;
            if (init_done !== m_run) begin
                fails++;
                $display("FAIL init_done t=%0t got %b exp %b", $time, init_done, m_run);
            end
            for (int i = 0; i < NRD; i++) begin
                tests++;
                if (rd_data[i] !== exp_rd(i)) begin
                    fails++;
                    $display("FAIL rd_data[%0d] t=%0t got %h exp %h", i, $time, rd_data[i], exp_rd(i));
                end
                tests++;
                if (rd_busy[i] !== exp_rbusy(i)) begin
                    fails++;
                    $display("FAIL rd_busy[%0d] t=%0t got %b exp %b", i, $time, rd_busy[i], exp_rbusy(i));
                end
            end
            tests++;
            if (busy_vec !== exp_bvec()) begin
                fails++;
                $display("FAIL busy_vec t=%0t got %h exp %h", $time, busy_vec, exp_bvec());
            end
            if (lit_kind != 0) begin
                case (lit_kind)
                    1:       act = {{(XLEN-1){1'b0}}, init_done};
                    2:       act = rd_data[lit_idx];
                    3:       act = {{(XLEN-1){1'b0}}, busy_vec[lit_idx]};
                    4:       act = {{(XLEN-1){1'b0}}, rd_busy[lit_idx]};
                    default: act = busy_vec;
                endcase
                tests++;
                if (act !== lit_exp) begin
                    fails++;
                    $display("FAIL %s t=%0t got %h exp %h", lit_name, $time, act, lit_exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        lit_kind = 0;
    endtask

    task automatic lit(input int k, input int idx, input logic [XLEN-1:0] e, input string n);
        lit_kind = k;
        lit_idx  = idx;
        lit_exp  = e;
        lit_name = n;
    endtask

    task automatic idle();
        rd_en    = '0;
        wr_en    = '0;
        iss_en   = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_addr = '0;
    endtask

    task automatic rand_in(input bit narrow);
        int hi;
        hi = narrow ? 7 : NREGS - 1;
        for (int i = 0; i < NRD; i++) begin
            rd_en[i]   = ($urandom_range(0, 3) != 0);
            rd_addr[i] = AW'($urandom_range(0, hi));
        end
        for (int j = 0; j < NWR; j++) begin
            wr_en[j]   = ($urandom_range(0, 2) == 0);
            wr_addr[j] = AW'($urandom_range(0, hi));
            wr_data[j] = $urandom;
        end
        iss_en   = ($urandom_range(0, 3) == 0);
        iss_addr = AW'($urandom_range(0, hi));
    endtask

    task automatic sweep_check(input string tag);
        for (int k = 1; k <= NREGS; k++) begin
            rand_in(1'b0);
            if (k == NREGS / 2) begin
                rd_en[0]   = 1'b1;
                rd_addr[0] = AW'(5);
                lit(2, 0, '0, {tag, "_init_rd"});
            end else begin
                lit(1, 0, '0, {tag, "_init_low"});
            end
            cyc();
        end
        idle();
        lit(1, 0, 1, {tag, "_init_high"});
        cyc();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        rst    = 1'b0;
        chk_on = 1'b1;
        sweep_check("rst1");

        // Bypass then storage read of x5.
        wr_en[0] = 1'b1; wr_addr[0] = AW'(5); wr_data[0] = 32'hDEADBEEF;
        rd_en[0] = 1'b1; rd_addr[0] = AW'(5);
        lit(2, 0, 32'hDEADBEEF, "byp_x5");
        cyc();
        wr_en = '0;
        lit(2, 0, 32'hDEADBEEF, "stor_x5");
        cyc();

        // Two ports on x7: port 1 wins.
        idle();
        wr_en = 2'b11;
        wr_addr[0] = AW'(7); wr_data[0] = 32'h11;
        wr_addr[1] = AW'(7); wr_data[1] = 32'h22;
        rd_en[1] = 1'b1; rd_addr[1] = AW'(7);
        lit(2, 1, 32'h22, "byp_x7");
        cyc();
        wr_en = '0;
        lit(2, 1, 32'h22, "stor_x7");
        cyc();

        // x0 discard, x3 holds 5, disabled port reads 0.
        idle();
        wr_en = 2'b11;
        wr_addr[0] = AW'(0); wr_data[0] = 32'hFFFFFFFF;
        wr_addr[1] = AW'(3); wr_data[1] = 32'h5;
        rd_en[0] = 1'b1; rd_addr[0] = AW'(0);
        lit(2, 0, '0, "wr_x0");
        cyc();
        wr_en = '0;
        lit(2, 0, '0, "stor_x0");
        cyc();
        rd_en = 2'b01; rd_addr[0] = AW'(3); rd_addr[1] = AW'(3);
        lit(2, 1, '0, "rd_dis_x3");
        cyc();
        lit(2, 0, 32'h5, "x3_val");
        cyc();

`ifdef REGFILE_SCOREBOARD_EN
        idle();
        iss_en = 1'b1; iss_addr = AW'(9);
        cyc();
        iss_en = 1'b0; rd_en[0] = 1'b1; rd_addr[0] = AW'(9);
        lit(3, 9, 1, "busy9_set");
        cyc();
        lit(4, 0, 1, "rdbusy9");
        cyc();
        iss_en = 1'b1; iss_addr = AW'(9);
        wr_en[0] = 1'b1; wr_addr[0] = AW'(9); wr_data[0] = 32'h99;
        lit(4, 0, 0, "rdbusy9_hit");
        cyc();
        idle();
        lit(3, 9, 1, "busy9_setwins");
        cyc();
        wr_en[0] = 1'b1; wr_addr[0] = AW'(9); wr_data[0] = 32'h9A;
        cyc();
        idle();
        lit(3, 9, 0, "busy9_clr");
        cyc();
        iss_en = 1'b1; iss_addr = AW'(0);
        cyc();
        iss_en = 1'b0;
        lit(5, 0, '0, "bvec_iss_x0");
        cyc();
`else
        idle();
        iss_en = 1'b1; iss_addr = AW'(9);
        cyc();
        iss_en = 1'b0;
        lit(5, 0, '0, "bvec_off");
        cyc();
`endif

        for (int n = 0; n < 1500; n++) begin
            rand_in($urandom_range(0, 3) != 0);
            cyc();
        end

        // Reset again, then interrupt the sweep at cycle 10.
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 1; k < 10; k++) begin
            rand_in(1'b0);
            cyc();
        end
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sweep_check("rst_mid");
        rd_en[0] = 1'b1; rd_addr[0] = AW'(5);
        lit(2, 0, '0, "swept_x5");
        cyc();

        for (int n = 0; n < 300; n++) begin
            rand_in($urandom_range(0, 1) != 0);
            cyc();
        end
        idle();
        cyc();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 XLEN, 32, data width in bits.
REQ-002 NREGS, 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 NRD, 2, read port count (>=1).
REQ-004 NWR, 2, write port count (>=1).
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 init_done  out  1  high once the register-clear sweep has completed.
REQ-008 rd_en  in  NRD  per-port read enable.
REQ-009 rd_addr  in  NRD x AW  per-port read address.
REQ-010 rd_data  out  NRD x XLEN  per-port read data, combinational.
REQ-011 rd_busy  out  NRD  per-port scoreboard pending flag, combinational.
REQ-012 wr_en  in  NWR  per-port write enable.
REQ-013 wr_addr  in  NWR x AW  per-port write address.
REQ-014 wr_data  in  NWR x XLEN  per-port write data.
REQ-015 iss_en  in  1  issue strobe; marks iss_addr as pending.
REQ-016 iss_addr  in  AW  destination register of the issued instruction.
REQ-017 busy_vec  out  NREGS  registered scoreboard bits; bit 0 always 0.

Function
REQ-018 FSM states INIT and RUN; INIT clears reg[cnt] to 0 each cycle, cnt 0..NREGS-1, then enters RUN with init_done=1 on the following cycle (NREGS cycles after rst deasserts).
REQ-019 In INIT: wr_en and iss_en ignored; rd_data=0, rd_busy=0.
REQ-020 In RUN: rd_data[i]=0 when rd_en[i]=0 or rd_addr[i]=0.
REQ-021 Bypass: if any wr_en[j] with wr_addr[j]=rd_addr[i]!=0, rd_data[i]=wr_data[j] in the same cycle; else rd_data[i]=reg[rd_addr[i]].
REQ-022 Multiple write ports hitting one address: highest-index port wins, for both storage and bypass.
REQ-023 Writes to address 0 are discarded; reg[0] stays 0.
REQ-024 Write latency: value visible from storage on the cycle after wr_en; visible via bypass in the write cycle.
REQ-025 Scoreboard: iss_en sets busy[iss_addr] next edge; any wr_en[j] clears busy[wr_addr[j]] next edge; iss_addr=0 ignored.
REQ-026 Same-cycle issue and write to the same address: set wins (busy stays 1).
REQ-027 rd_busy[i]=busy[rd_addr[i]] AND NOT (same-cycle write hit on rd_addr[i]); 0 when rd_en[i]=0.

Reset
REQ-028 rst in any state (including mid-INIT) returns FSM to INIT, cnt=0, init_done=0, busy_vec=0.
REQ-029 Register contents are not cleared by rst directly; cleared only by the INIT sweep.

Configuration
REQ-030 With REGFILE_SCOREBOARD_EN defined: REQ-025..027 implemented, busy_vec registered.
REQ-031 Without REGFILE_SCOREBOARD_EN: busy_vec=0, rd_busy=0, iss_en/iss_addr ignored; no scoreboard flops.

Structure
REQ-032 Shared package regfile_pkg holds FSM state enum (RF_INIT, RF_RUN) and default parameter constants.
REQ-033 One sub-module regfile_wr_arb resolves per-address highest-index write winner; used for storage and bypass.

Verification
REQ-034 rst 1 cycle, NREGS=32 -> init_done=0 for 32 cycles, 1 on cycle 33; all reads return 0.
REQ-035 RUN: write x5=0xDEADBEEF on port0 while reading x5 -> rd_data=0xDEADBEEF same cycle; next cycle from storage.
REQ-036 Ports 0 and 1 write x7 with 0x11 and 0x22 -> rd_data(x7)=0x22 same and next cycle.
REQ-037 Write x0=0xFFFFFFFF, read x0 -> 0; rd_en=0 on x3 holding 0x5 -> 0.
REQ-038 Scoreboard on: iss x9 -> busy_vec[9]=1; write x9 while issuing x9 -> stays 1; later write x9 -> 0; iss x0 -> no change.
REQ-039 rst asserted at sweep cycle 10 -> cnt restarts, init_done after full 32 further cycles.
